// File: rtl/rv_pipe_pkg.sv
// Shared definitions for the RV64 pipeline: ALUOp classes, ALU operation codes,
// WB/M control field layouts and the branch Funct codes used by the EX stage.
// Latency: n/a (definitions only). Backpressure: n/a.
package rv_pipe_pkg;

  localparam int XLEN = 64;
  localparam int REGW = 5;

  // ALU class coming from main decode.
  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,  // loads/stores: address add
    ALUOP_SUB   = 2'b01,  // branches: compare by subtract
    ALUOP_RTYPE = 2'b10,  // register-register, full Funct
    ALUOP_ITYPE = 2'b11   // register-immediate, Funct[2:0] only
  } aluop_e;

  // Operation actually performed by the ALU.
  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_OR  = 2'b11
  } alu_op_e;

  // WB control: {RegWrite, MemtoReg}.
  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
  } wb_t;

  // M control: {Branch, MemRead, MemWrite}.
  typedef struct packed {
    logic branch;
    logic mem_read;
    logic mem_write;
  } m_t;

  localparam logic [2:0] FUNCT_BEQ = 3'b000;
  localparam logic [2:0] FUNCT_BNE = 3'b001;

  // Operand forwarding: the younger MEM result beats WB; x0 never forwards.
  function automatic logic [XLEN-1:0] fwd_sel(
    input logic [REGW-1:0] rs,
    input logic [XLEN-1:0] rf_data,
    input logic            mem_we,
    input logic [REGW-1:0] mem_rd,
    input logic [XLEN-1:0] mem_data,
    input logic            wb_we,
    input logic [REGW-1:0] wb_rd,
    input logic [XLEN-1:0] wb_data
  );
    logic [XLEN-1:0] r;
    r = rf_data;
    if (mem_we && (mem_rd != '0) && (mem_rd == rs)) begin
      r = mem_data;
    end else if (wb_we && (wb_rd != '0) && (wb_rd == rs)) begin
      r = wb_data;
    end
    return r;
  endfunction

endpackage

// File: rtl/alu_ctrl.sv
// ALU control decode: maps {ALUOp, Funct} to an ALU operation; unknown codes add.
// Latency: combinational. Backpressure: none (pure function of inputs).
// Ports: aluop (ALU class), funct ({inst[30], inst[14:12]}), alu_op (selected op).
module alu_ctrl
  import rv_pipe_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [3:0] funct,
  output alu_op_e    alu_op
);

  always_comb begin
    alu_op = ALU_ADD;
    case (aluop)
      ALUOP_ADD: alu_op = ALU_ADD;
      ALUOP_SUB: alu_op = ALU_SUB;
      ALUOP_RTYPE: begin
        case (funct)
          4'b0000: alu_op = ALU_ADD;
          4'b1000: alu_op = ALU_SUB;
          4'b0111: alu_op = ALU_AND;
          4'b0110: alu_op = ALU_OR;
          default: alu_op = ALU_ADD;
        endcase
      end
      ALUOP_ITYPE: begin
        // inst[30] is part of the immediate here, so only funct3 matters.
        case (funct[2:0])
          3'b111:  alu_op = ALU_AND;
          3'b110:  alu_op = ALU_OR;
          default: alu_op = ALU_ADD;
        endcase
      end
      default: alu_op = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: forwarding, ALU, branch compare/target, registered EX/MEM payload.
// Latency: 1 cycle ID/EX -> EX/MEM. Backpressure: out_ready low holds the payload and
// drops in_ready; a taken branch (PCSrc) drops the wrong-path instruction in its cycle.
// Ports: clk/reset (async, active-low); in_valid/in_ready + ID/EX fields; Fwd_* from
// MEM/WB; out_valid/out_ready + EX/MEM fields; PCSrc redirects fetch.
module ex_stage
  import rv_pipe_pkg::*;
#(
  parameter int XLEN_P = XLEN,
  parameter int REGW_P = REGW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN_P-1:0] Inst_Addr,
  input  logic [REGW_P-1:0] RS1,
  input  logic [REGW_P-1:0] RS2,
  input  logic [REGW_P-1:0] RD,
  input  logic [XLEN_P-1:0] ReadData1,
  input  logic [XLEN_P-1:0] ReadData2,
  input  logic [XLEN_P-1:0] ImmediateData,
  input  logic [3:0]        Funct,
  input  logic [1:0]        WB,
  input  logic [2:0]        M,
  input  logic [1:0]        ALUOp,
  input  logic              ALUSrc,
  input  logic              Fwd_MEM_RegWrite,
  input  logic              Fwd_WB_RegWrite,
  input  logic [REGW_P-1:0] Fwd_MEM_RD,
  input  logic [REGW_P-1:0] Fwd_WB_RD,
  input  logic [XLEN_P-1:0] Fwd_MEM_Data,
  input  logic [XLEN_P-1:0] Fwd_WB_Data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN_P-1:0] ALU_Result,
  output logic              Zero,
  output logic [XLEN_P-1:0] WriteData,
  output logic [XLEN_P-1:0] Branch_Target,
  output logic [REGW_P-1:0] RD_Out,
  output logic [1:0]        WB_Out,
  output logic [2:0]        M_Out,
  output logic              PCSrc
);

  logic [XLEN_P-1:0] op_a;
  logic [XLEN_P-1:0] rs2_fwd;
  logic [XLEN_P-1:0] op_b;
  logic [XLEN_P-1:0] alu_res;
  logic              alu_zero;
  logic              taken;
  logic              taken_q;
  logic              load;
  alu_op_e           alu_op;
  m_t                m_in;

  assign m_in = m_t'(M);

  assign op_a    = fwd_sel(RS1, ReadData1, Fwd_MEM_RegWrite, Fwd_MEM_RD, Fwd_MEM_Data,
                           Fwd_WB_RegWrite, Fwd_WB_RD, Fwd_WB_Data);
  assign rs2_fwd = fwd_sel(RS2, ReadData2, Fwd_MEM_RegWrite, Fwd_MEM_RD, Fwd_MEM_Data,
                           Fwd_WB_RegWrite, Fwd_WB_RD, Fwd_WB_Data);
  assign op_b    = ALUSrc ? ImmediateData : rs2_fwd;

  alu_ctrl u_alu_ctrl (
    .aluop  (ALUOp),
    .funct  (Funct),
    .alu_op (alu_op)
  );

  always_comb begin
    alu_res = op_a + op_b;
    case (alu_op)
      ALU_ADD: alu_res = op_a + op_b;
      ALU_SUB: alu_res = op_a - op_b;
      ALU_AND: alu_res = op_a & op_b;
      ALU_OR:  alu_res = op_a | op_b;
      default: alu_res = op_a + op_b;
    endcase
  end

  assign alu_zero = (alu_res == '0);

  // Branch decision uses the subtract result; only BEQ/BNE are resolved here.
  assign taken = m_in.branch &&
                 (((Funct[2:0] == FUNCT_BEQ) && alu_zero) ||
                  ((Funct[2:0] == FUNCT_BNE) && !alu_zero));

  assign in_ready = out_ready || !out_valid;
  // Redirect fires only when the taken branch actually leaves for MEM.
  assign PCSrc    = out_valid && out_ready && taken_q;
  // The instruction behind a redirecting branch is wrong-path: accept and drop it.
  assign load     = in_valid && in_ready && !PCSrc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid     <= 1'b0;
      ALU_Result    <= '0;
      Zero          <= 1'b0;
      WriteData     <= '0;
      Branch_Target <= '0;
      RD_Out        <= '0;
      WB_Out        <= '0;
      M_Out         <= '0;
      taken_q       <= 1'b0;
    end else if (load) begin
      out_valid     <= 1'b1;
      ALU_Result    <= alu_res;
      Zero          <= alu_zero;
      WriteData     <= rs2_fwd;
      Branch_Target <= Inst_Addr + (ImmediateData << 1);
      RD_Out        <= RD;
      WB_Out        <= WB;
      M_Out         <= M;
      taken_q       <= taken;
    end else if (in_ready) begin
      // Payload is left as-is; only the valid flag retires.
      out_valid     <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
module tb_ex_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] Inst_Addr;
  logic [4:0]  RS1, RS2, RD;
  logic [63:0] ReadData1, ReadData2, ImmediateData;
  logic [3:0]  Funct;
  logic [1:0]  WB;
  logic [2:0]  M;
  logic [1:0]  ALUOp;
  logic        ALUSrc;
  logic        Fwd_MEM_RegWrite, Fwd_WB_RegWrite;
  logic [4:0]  Fwd_MEM_RD, Fwd_WB_RD;
  logic [63:0] Fwd_MEM_Data, Fwd_WB_Data;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] ALU_Result;
  logic        Zero;
  logic [63:0] WriteData;
  logic [63:0] Branch_Target;
  logic [4:0]  RD_Out;
  logic [1:0]  WB_Out;
  logic [2:0]  M_Out;
  logic        PCSrc;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  ex_stage dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .Inst_Addr(Inst_Addr), .RS1(RS1), .RS2(RS2), .RD(RD),
    .ReadData1(ReadData1), .ReadData2(ReadData2), .ImmediateData(ImmediateData),
    .Funct(Funct), .WB(WB), .M(M), .ALUOp(ALUOp), .ALUSrc(ALUSrc),
    .Fwd_MEM_RegWrite(Fwd_MEM_RegWrite), .Fwd_WB_RegWrite(Fwd_WB_RegWrite),
    .Fwd_MEM_RD(Fwd_MEM_RD), .Fwd_WB_RD(Fwd_WB_RD),
    .Fwd_MEM_Data(Fwd_MEM_Data), .Fwd_WB_Data(Fwd_WB_Data),
    .out_valid(out_valid), .out_ready(out_ready),
    .ALU_Result(ALU_Result), .Zero(Zero), .WriteData(WriteData),
    .Branch_Target(Branch_Target), .RD_Out(RD_Out), .WB_Out(WB_Out),
    .M_Out(M_Out), .PCSrc(PCSrc)
  );

  // Reference model state: what MEM should currently be seeing.
  typedef struct packed {
    logic [63:0] res;
    logic        zero;
    logic [63:0] wdata;
    logic [63:0] bt;
    logic [4:0]  rd;
    logic [1:0]  wb;
    logic [2:0]  m;
    logic        taken;
  } pay_t;

  logic m_valid;
  pay_t m_pay;
  logic n_valid;
  pay_t n_pay;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] operand(input logic [4:0] rs, input logic [63:0] rf);
    if (rs != 0 && Fwd_MEM_RegWrite && Fwd_MEM_RD == rs) return Fwd_MEM_Data;
    if (rs != 0 && Fwd_WB_RegWrite && Fwd_WB_RD == rs) return Fwd_WB_Data;
    return rf;
  endfunction

  function automatic pay_t model_exec();
    pay_t p;
    logic [63:0] a, s2, b, r;
    a  = operand(RS1, ReadData1);
    s2 = operand(RS2, ReadData2);
    b  = ALUSrc ? ImmediateData : s2;
    r  = a + b;
    if (ALUOp == 2'd1) r = a - b;
    else if (ALUOp == 2'd2) begin
      if (Funct == 4'b1000) r = a - b;
      else if (Funct == 4'b0111) r = a & b;
      else if (Funct == 4'b0110) r = a | b;
    end else if (ALUOp == 2'd3) begin
      if (Funct[2:0] == 3'b111) r = a & b;
      else if (Funct[2:0] == 3'b110) r = a | b;
    end
    p.res   = r;
    p.zero  = (r == 64'd0);
    p.wdata = s2;
    p.bt    = Inst_Addr + ImmediateData * 64'd2;
    p.rd    = RD;
    p.wb    = WB;
    p.m     = M;
    p.taken = M[2] && ((Funct[2:0] == 3'd0 && r == 64'd0) || (Funct[2:0] == 3'd1 && r != 64'd0));
    return p;
  endfunction

  // Combinational checks for the current cycle and the model's next state.
  task automatic pre();
    logic exp_rdy, exp_pcs;
    #2;
    exp_rdy = out_ready || !m_valid;
    exp_pcs = m_valid && out_ready && m_pay.taken;
    check("in_ready", in_ready, exp_rdy);
    check("PCSrc", PCSrc, exp_pcs);
    n_valid = m_valid;
    n_pay   = m_pay;
    if (in_valid && exp_rdy && !exp_pcs) begin
      n_valid = 1'b1;
      n_pay   = model_exec();
    end else if (exp_rdy) begin
      n_valid = 1'b0;
    end
  endtask

  task automatic post();
    @(posedge clk);
    m_valid = n_valid;
    m_pay   = n_pay;
    #1;
    check("out_valid", out_valid, m_valid);
    check("ALU_Result", ALU_Result, m_pay.res);
    check("Zero", Zero, m_pay.zero);
    check("WriteData", WriteData, m_pay.wdata);
    check("Branch_Target", Branch_Target, m_pay.bt);
    check("RD_Out", RD_Out, m_pay.rd);
    check("WB_Out", WB_Out, m_pay.wb);
    check("M_Out", M_Out, m_pay.m);
  endtask

  task automatic step();
    pre();
    post();
  endtask

  task automatic set_inst(input logic [63:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [4:0] rd, input logic [63:0] d1, input logic [63:0] d2,
                          input logic [63:0] imm, input logic [3:0] f, input logic [1:0] aop,
                          input logic [2:0] m, input logic src);
    in_valid = 1'b1;
    Inst_Addr = pc; RS1 = rs1; RS2 = rs2; RD = rd;
    ReadData1 = d1; ReadData2 = d2; ImmediateData = imm;
    Funct = f; ALUOp = aop; M = m; ALUSrc = src; WB = 2'b10;
    Fwd_MEM_RegWrite = 0; Fwd_WB_RegWrite = 0;
    Fwd_MEM_RD = 0; Fwd_WB_RD = 0; Fwd_MEM_Data = 0; Fwd_WB_Data = 0;
  endtask

  function automatic logic [63:0] rnd_data();
    if ($urandom_range(0, 1) == 0) return 64'($urandom_range(0, 3));
    return {$urandom, $urandom};
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_pay   = '0;
  endtask

  initial begin
    reset = 1'b0;
    out_ready = 1'b1;
    set_inst(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    in_valid = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_PCSrc", PCSrc, 0);
    check("rst_ALU_Result", ALU_Result, 0);
    check("rst_Branch_Target", Branch_Target, 0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // R-type add.
    set_inst(64'h100, 1, 2, 5, 5, 7, 0, 4'b0000, 2'b10, 3'b000, 0);
    step();
    check("radd_valid", out_valid, 1);
    check("radd_res", ALU_Result, 12);
    check("radd_zero", Zero, 0);

    // Forwarding priority: MEM beats WB.
    set_inst(64'h104, 3, 4, 6, 1, 1, 0, 4'b0000, 2'b01, 3'b000, 0);
    Fwd_MEM_RegWrite = 1; Fwd_MEM_RD = 3; Fwd_MEM_Data = 100;
    Fwd_WB_RegWrite = 1; Fwd_WB_RD = 3; Fwd_WB_Data = 200;
    step();
    check("fwd_mem_res", ALU_Result, 99);
    // x0 never forwards.
    RS1 = 0; Fwd_MEM_RD = 0; Fwd_WB_RD = 0;
    step();
    check("fwd_x0_res", ALU_Result, 0);
    check("fwd_x0_zero", Zero, 1);

    // Taken BEQ, then the next instruction is dropped.
    set_inst(64'h1000, 7, 8, 0, 9, 9, 8, 4'b0000, 2'b01, 3'b100, 0);
    step();
    check("beq_target", Branch_Target, 64'h1010);
    check("beq_zero", Zero, 1);
    set_inst(64'h1004, 1, 2, 9, 3, 4, 0, 4'b0000, 2'b10, 3'b000, 0);
    pre();
    check("beq_pcsrc", PCSrc, 1);
    check("beq_in_ready", in_ready, 1);
    post();
    check("beq_drop_valid", out_valid, 0);
    in_valid = 1'b0;
    step();
    check("beq_pcsrc_once", PCSrc, 0);

    // Back-pressure for three cycles, then release with a new load in the same cycle.
    set_inst(64'h200, 1, 2, 10, 20, 22, 0, 4'b0000, 2'b10, 3'b000, 0);
    step();
    set_inst(64'h204, 1, 2, 11, 8, 3, 0, 4'b1000, 2'b10, 3'b000, 0);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      pre();
      check("bp_in_ready", in_ready, 0);
      check("bp_pcsrc", PCSrc, 0);
      post();
      check("bp_hold_res", ALU_Result, 42);
      check("bp_hold_rd", RD_Out, 10);
    end
    out_ready = 1'b1;
    step();
    check("bp_release_valid", out_valid, 1);
    check("bp_release_res", ALU_Result, 5);
    check("bp_release_rd", RD_Out, 11);

    // BNE with equal operands is not taken.
    set_inst(64'h300, 1, 2, 0, 9, 9, 4, 4'b0001, 2'b01, 3'b100, 0);
    step();
    set_inst(64'h304, 1, 0, 12, 64'hFF, 0, 64'hF0, 4'b0111, 2'b11, 3'b000, 1);
    pre();
    check("bne_pcsrc", PCSrc, 0);
    post();
    check("andi_res", ALU_Result, 64'hF0);

    // Reset while stalled clears everything without a clock edge.
    set_inst(64'h400, 1, 2, 13, 1, 2, 0, 4'b0000, 2'b10, 3'b000, 0);
    step();
    out_ready = 1'b0;
    step();
    reset = 1'b0;
    #1;
    model_reset();
    check("mrst_out_valid", out_valid, 0);
    check("mrst_res", ALU_Result, 0);
    check("mrst_rd", RD_Out, 0);
    check("mrst_wb", WB_Out, 0);
    check("mrst_in_ready", in_ready, 1);
    @(negedge clk);
    reset = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      in_valid = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 3) != 0);
      Inst_Addr = {$urandom, $urandom};
      RS1 = 5'($urandom_range(0, 3));
      RS2 = 5'($urandom_range(0, 3));
      RD = 5'($urandom);
      ReadData1 = rnd_data();
      ReadData2 = rnd_data();
      ImmediateData = rnd_data();
      Funct = 4'($urandom);
      WB = 2'($urandom);
      M = 3'($urandom);
      ALUOp = 2'($urandom);
      ALUSrc = ($urandom_range(0, 3) == 0);
      Fwd_MEM_RegWrite = 1'($urandom);
      Fwd_WB_RegWrite = 1'($urandom);
      Fwd_MEM_RD = 5'($urandom_range(0, 3));
      Fwd_WB_RD = 5'($urandom_range(0, 3));
      Fwd_MEM_Data = rnd_data();
      Fwd_WB_Data = rnd_data();
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
